// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver (and matching TX).
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    // Oversample tick divider, integer truncation.
    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned baud,
                                             input int unsigned oversample);
        return clk_freq / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversample tick generator: one-clk tick every DIV clks, restartable via clr.
module uart_os_tick #(
    parameter int unsigned DIV = 54
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt;

    // Free-running divider, held at zero while clr is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == CNT_W'(DIV - 1)) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with integrated oversample tick, majority-vote
// sampling and parity / framing / break reporting.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 d_in,
    input  logic                 rx_en,
    input  logic [1:0]           parity_mode,
    output logic [DATA_BITS-1:0] d_out,
    output logic                 done,
    output logic                 start,
    output logic                 busy,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det
);

    localparam int unsigned DIV  = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int unsigned H    = OVERSAMPLE / 2;
    localparam int unsigned SC_W = $clog2(OVERSAMPLE);
    localparam int unsigned BC_W = $clog2(DATA_BITS);

    rx_state_t state_q, state_n;

    logic                 rx_meta, rxs, rxs_d;
    logic                 os_tick, tick_clr;
    logic [SC_W-1:0]      sc;
    logic                 s_a, s_b, maj;
    logic                 mid_c, end_c, edge_c;
    logic [BC_W-1:0]      bit_cnt;
    logic                 stop_cnt;
    logic [1:0]           par_q;
    logic                 par_en;
    logic [DATA_BITS-1:0] shadow;
    logic                 perr, ferr, pbit, ferr_now;
    logic                 low_seen;
    logic                 start_c, done_c;

    // Two-flop synchroniser plus one delayed copy for falling-edge detect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
        end else begin
            rx_meta <= d_in;
            rxs     <= rx_meta;
            rxs_d   <= rxs;
        end
    end

    // Divider is held in IDLE, so it restarts on the start-edge clk.
    assign tick_clr = (state_q == IDLE);

    uart_os_tick #(
        .DIV (DIV)
    ) u_os_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (tick_clr),
        .tick (os_tick)
    );

    assign edge_c   = rx_en && (state_q == IDLE) && rxs_d && !rxs;
    assign maj      = (s_a & s_b) | (s_a & rxs) | (s_b & rxs);
    assign mid_c    = os_tick && (sc == SC_W'(H + 1));
    assign end_c    = os_tick && (sc == SC_W'(OVERSAMPLE - 1));
    assign par_en   = (par_q == PAR_ODD) || (par_q == PAR_EVEN);
    assign ferr_now = ferr | ~maj;

    // Per-bit sample counter and the two early majority samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sc  <= '0;
            s_a <= 1'b0;
            s_b <= 1'b0;
        end else if (state_q == IDLE) begin
            sc <= '0;
        end else if (os_tick) begin
            if (sc == SC_W'(H - 1)) s_a <= rxs;
            if (sc == SC_W'(H))     s_b <= rxs;
            sc <= (sc == SC_W'(OVERSAMPLE - 1)) ? '0 : sc + 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_n;
    end

    // Next-state logic and single-cycle strobes.
    always_comb begin
        state_n = state_q;
        start_c = 1'b0;
        done_c  = 1'b0;
        if (!rx_en) begin
            state_n = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (edge_c) state_n = START;
                end
                START: begin
                    if (mid_c) begin
                        if (maj) state_n = IDLE;
                        else     start_c = 1'b1;
                    end else if (end_c) begin
                        state_n = DATA;
                    end
                end
                DATA: begin
                    if (end_c && (bit_cnt == BC_W'(DATA_BITS - 1)))
                        state_n = par_en ? PARITY : STOP;
                end
                PARITY: begin
                    if (end_c) state_n = STOP;
                end
                STOP: begin
                    if (mid_c && (stop_cnt == 1'(STOP_BITS - 1))) begin
                        done_c  = 1'b1;
                        state_n = ferr_now ? WAIT_HIGH : IDLE;
                    end
                end
                WAIT_HIGH: begin
                    if (os_tick && rxs && !low_seen) state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Frame datapath: shift register, bit counters and internal error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_q    <= PAR_NONE;
            perr     <= 1'b0;
            ferr     <= 1'b0;
            pbit     <= 1'b0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            shadow   <= '0;
        end else if (edge_c) begin
            par_q    <= parity_mode;
            perr     <= 1'b0;
            ferr     <= 1'b0;
            pbit     <= 1'b0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
        end else begin
            case (state_q)
                DATA: begin
                    if (mid_c) shadow <= {maj, shadow[DATA_BITS-1:1]};
                    if (end_c) bit_cnt <= bit_cnt + 1'b1;
                end
                PARITY: begin
                    if (mid_c) begin
                        pbit <= maj;
                        perr <= (^shadow) ^ maj ^ (par_q == PAR_ODD);
                    end
                end
                STOP: begin
                    if (mid_c && !maj) ferr <= 1'b1;
                    if (end_c) stop_cnt <= stop_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Tracks any low rxs within the current tick period while waiting for release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       low_seen <= 1'b1;
        else if (state_q != WAIT_HIGH) low_seen <= 1'b1;
        else if (os_tick)              low_seen <= ~rxs;
        else if (!rxs)                 low_seen <= 1'b1;
    end

    // Registered outputs; word and error flags only change with done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_out      <= '0;
            done       <= 1'b0;
            start      <= 1'b0;
            busy       <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
        end else begin
            done  <= done_c;
            start <= start_c;
            busy  <= (state_n == START) || (state_n == DATA) ||
                     (state_n == PARITY) || (state_n == STOP);
            if (done_c) begin
                d_out      <= shadow;
                parity_err <= perr;
                frame_err  <= ferr_now;
                break_det  <= ferr_now && (shadow == '0) && !(par_en && pbit);
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param, run at a fast line rate (64 clks/bit).
module tb_uart_rx_param;

    localparam int unsigned CLK_FREQ = 100000000;
    localparam int unsigned BAUD     = 1562500;
    localparam int unsigned OS       = 16;
    localparam int unsigned BIT_CLKS = 64;

    logic       clk = 1'b0;
    logic       rst, d_in, rx_en;
    logic [1:0] parity_mode;
    logic [7:0] d_out;
    logic       done, start, busy, parity_err, frame_err, break_det;

    int total = 0;
    int bad   = 0;
    int start_cnt = 0;
    int done_cnt  = 0;
    logic [10:0] rec_q[$];
    time         done_t[$];
    logic [10:0] last_exp = '0;

    uart_rx_param #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OS),
        .DATA_BITS  (8),
        .STOP_BITS  (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .d_in        (d_in),
        .rx_en       (rx_en),
        .parity_mode (parity_mode),
        .d_out       (d_out),
        .done        (done),
        .start       (start),
        .busy        (busy),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .break_det   (break_det)
    );

    always #5 clk = ~clk;

    // Pulse monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        if (start) start_cnt++;
        if (done) begin
            done_cnt++;
            rec_q.push_back({break_det, frame_err, parity_err, d_out});
            done_t.push_back($time);
        end
    end

    // Reference: expected {break, frame, parity, data} straight from the frame contents.
    function automatic logic [10:0] model(input logic [7:0] data, input logic [1:0] mode,
                                          input logic pbit, input logic stop_v);
        logic has_par, perr, ferr, brk;
        int   ones;
        has_par = (mode == 2'b01) || (mode == 2'b10);
        ones    = $countones(data) + (has_par ? int'(pbit) : 0);
        perr    = has_par && ((mode == 2'b01) ? (ones % 2 == 0) : (ones % 2 == 1));
        ferr    = !stop_v;
        brk     = ferr && (data == 8'h00) && !(has_par && pbit);
        return {brk, ferr, perr, data};
    endfunction

    task automatic send_bit(input logic b);
        d_in = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        d_in = 1'b1;
        repeat (n * BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic has_par,
                              input logic pbit, input logic stop_v);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(data[i]);
        if (has_par) send_bit(pbit);
        send_bit(stop_v);
    endtask

    task automatic test_reset();
        rst = 1'b1; d_in = 1'b1; rx_en = 1'b1; parity_mode = 2'b00;
        repeat (3) @(negedge clk);
        total++;
        if ({d_out, done, start, parity_err, frame_err, break_det} !== 13'h0) begin
            bad++; $display("FAIL reset_outputs got=%h want=0", {d_out, done, start, parity_err, frame_err, break_det});
        end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        rst = 1'b0;
        idle_bits(1);
    endtask

    task automatic test_8n1();
        int s0, d0;
        logic [10:0] r, e;
        rec_q.delete(); s0 = start_cnt; d0 = done_cnt;
        parity_mode = 2'b00;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        idle_bits(1);
        e = model(8'hA5, 2'b00, 1'b0, 1'b1);
        total++;
        if (start_cnt - s0 != 1) begin bad++; $display("FAIL 8n1_starts got=%0d want=1", start_cnt - s0); end
        total++;
        if (done_cnt - d0 != 1 || rec_q.size() != 1) begin
            bad++; $display("FAIL 8n1_dones got=%0d want=1", done_cnt - d0);
        end else begin
            r = rec_q.pop_front(); total++;
            if (r !== e) begin bad++; $display("FAIL 8n1_word got=%h want=%h", r, e); end
            last_exp = e;
        end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL 8n1_busy_after got=%b want=0", busy); end
    endtask

    task automatic test_parity_even();
        logic [7:0]  dv[2] = '{8'h03, 8'h07};
        logic [10:0] r, e;
        parity_mode = 2'b10;
        for (int k = 0; k < 2; k++) begin
            rec_q.delete();
            send_frame(dv[k], 1'b1, 1'b1, 1'b1);
            idle_bits(1);
            e = model(dv[k], 2'b10, 1'b1, 1'b1);
            total++;
            if (rec_q.size() != 1) begin
                bad++; $display("FAIL even_par_dones frame=%0d got=%0d want=1", k, rec_q.size());
            end else begin
                r = rec_q.pop_front(); total++;
                if (r !== e) begin bad++; $display("FAIL even_par_word frame=%0d got=%h want=%h", k, r, e); end
                last_exp = e;
            end
        end
        parity_mode = 2'b00;
    endtask

    task automatic test_frame_err();
        int s0;
        logic [10:0] r, e;
        rec_q.delete(); s0 = start_cnt;
        send_frame(8'h55, 1'b0, 1'b0, 1'b0);
        // Line stays low with a blip shorter than one tick: must not re-arm.
        send_bit(1'b0);
        d_in = 1'b1; repeat (2) @(negedge clk);
        send_bit(1'b0);
        idle_bits(2);
        e = model(8'h55, 2'b00, 1'b0, 1'b0);
        total++;
        if (start_cnt - s0 != 1) begin bad++; $display("FAIL ferr_rearm starts got=%0d want=1", start_cnt - s0); end
        total++;
        if (rec_q.size() != 1) begin
            bad++; $display("FAIL ferr_dones got=%0d want=1", rec_q.size());
        end else begin
            r = rec_q.pop_front(); total++;
            if (r !== e) begin bad++; $display("FAIL ferr_word got=%h want=%h", r, e); end
            last_exp = e;
        end
    endtask

    task automatic test_break();
        logic [10:0] r, e;
        rec_q.delete();
        d_in = 1'b0;
        repeat (12 * BIT_CLKS) @(negedge clk);
        idle_bits(2);
        e = model(8'h00, 2'b00, 1'b0, 1'b0);
        total++;
        if (rec_q.size() != 1) begin
            bad++; $display("FAIL break_dones got=%0d want=1", rec_q.size());
        end else begin
            r = rec_q.pop_front(); total++;
            if (r !== e) begin bad++; $display("FAIL break_word got=%h want=%h", r, e); end
        end
        rec_q.delete();
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        idle_bits(1);
        e = model(8'h3C, 2'b00, 1'b0, 1'b1);
        total++;
        if (rec_q.size() != 1) begin
            bad++; $display("FAIL post_break_dones got=%0d want=1", rec_q.size());
        end else begin
            r = rec_q.pop_front(); total++;
            if (r !== e) begin bad++; $display("FAIL post_break_word got=%h want=%h", r, e); end
            last_exp = e;
        end
    endtask

    task automatic test_glitch();
        int   s0, d0;
        logic busy_seen;
        s0 = start_cnt; d0 = done_cnt; busy_seen = 1'b0;
        d_in = 1'b0;
        repeat (10) @(negedge clk) if (busy) busy_seen = 1'b1;
        d_in = 1'b1;
        repeat (BIT_CLKS) @(negedge clk) if (busy) busy_seen = 1'b1;
        total++;
        if (busy_seen !== 1'b1) begin bad++; $display("FAIL glitch_busy_seen got=%b want=1", busy_seen); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL glitch_busy_end got=%b want=0", busy); end
        total++;
        if ((start_cnt - s0) + (done_cnt - d0) != 0) begin
            bad++; $display("FAIL glitch_pulses got=%0d want=0", (start_cnt - s0) + (done_cnt - d0));
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] r, e;
        longint      dt;
        rec_q.delete(); done_t.delete();
        send_frame(8'h12, 1'b0, 1'b0, 1'b1);
        send_frame(8'h34, 1'b0, 1'b0, 1'b1);
        idle_bits(1);
        total++;
        if (rec_q.size() != 2 || done_t.size() != 2) begin
            bad++; $display("FAIL b2b_dones got=%0d want=2", rec_q.size());
        end else begin
            r = rec_q.pop_front(); e = model(8'h12, 2'b00, 1'b0, 1'b1); total++;
            if (r !== e) begin bad++; $display("FAIL b2b_word0 got=%h want=%h", r, e); end
            r = rec_q.pop_front(); e = model(8'h34, 2'b00, 1'b0, 1'b1); total++;
            if (r !== e) begin bad++; $display("FAIL b2b_word1 got=%h want=%h", r, e); end
            last_exp = e;
            dt = longint'(done_t[1] - done_t[0]) / 10;
            total++;
            if (dt < 10 * BIT_CLKS - 2 || dt > 10 * BIT_CLKS + 2) begin
                bad++; $display("FAIL b2b_spacing got=%0d clks want=%0d", dt, 10 * BIT_CLKS);
            end
        end
    endtask

    task automatic test_rx_en_drop();
        int d0;
        logic [7:0] data;
        d0 = done_cnt; data = 8'hE7;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(data[i]);
        rx_en = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL en_drop_busy got=%b want=0", busy); end
        for (int i = 4; i < 8; i++) send_bit(data[i]);
        send_bit(1'b1);
        idle_bits(1);
        rx_en = 1'b1;
        idle_bits(1);
        total++;
        if (done_cnt != d0) begin bad++; $display("FAIL en_drop_done got=%0d want=0", done_cnt - d0); end
        total++;
        if ({break_det, frame_err, parity_err, d_out} !== last_exp) begin
            bad++; $display("FAIL en_drop_hold got=%h want=%h", {break_det, frame_err, parity_err, d_out}, last_exp);
        end
    endtask

    task automatic test_parity_latch();
        logic [10:0] r, e;
        rec_q.delete();
        parity_mode = 2'b01;
        send_bit(1'b0);
        parity_mode = 2'b00;
        for (int i = 0; i < 8; i++) send_bit(i == 0);
        send_bit(1'b0);
        send_bit(1'b1);
        idle_bits(1);
        e = model(8'h01, 2'b01, 1'b0, 1'b1);
        total++;
        if (rec_q.size() != 1) begin
            bad++; $display("FAIL latch_dones got=%0d want=1", rec_q.size());
        end else begin
            r = rec_q.pop_front(); total++;
            if (r !== e) begin bad++; $display("FAIL latch_word got=%h want=%h", r, e); end
            last_exp = e;
        end
    endtask

    task automatic test_random();
        logic [7:0]  data;
        logic [1:0]  mode;
        logic        pbit, stop_v, has_par;
        logic [10:0] r, e;
        for (int k = 0; k < 10; k++) begin
            data    = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            mode    = 2'($urandom_range(0, 3));
            pbit    = 1'($urandom);
            stop_v  = ($urandom_range(0, 3) != 0);
            has_par = (mode == 2'b01) || (mode == 2'b10);
            parity_mode = mode;
            rec_q.delete();
            send_frame(data, has_par, pbit, stop_v);
            idle_bits(1 + int'($urandom_range(0, 1)));
            e = model(data, mode, pbit, stop_v);
            total++;
            if (rec_q.size() != 1) begin
                bad++; $display("FAIL rand_dones frame=%0d got=%0d want=1", k, rec_q.size());
            end else begin
                r = rec_q.pop_front(); total++;
                if (r !== e) begin bad++; $display("FAIL rand_word frame=%0d mode=%0d got=%h want=%h", k, mode, r, e); end
                last_exp = e;
            end
        end
        parity_mode = 2'b00;
    endtask

    task automatic test_mid_reset();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({d_out, busy, parity_err, frame_err, break_det} !== 12'h0) begin
            bad++; $display("FAIL mid_reset got=%h want=0", {d_out, busy, parity_err, frame_err, break_det});
        end
        rst = 1'b0;
        idle_bits(2);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL mid_reset_idle got=%b want=0", busy); end
    endtask

    initial begin
        rst = 1'b1; d_in = 1'b1; rx_en = 1'b1; parity_mode = 2'b00;
        test_reset();
        test_8n1();
        test_parity_even();
        test_frame_err();
        test_break();
        test_glitch();
        test_back_to_back();
        test_rx_en_drop();
        test_parity_latch();
        test_random();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
